// File: rtl/alu_pkg.sv
// Shared encodings for the ALU issue unit: MIPS opcode/funct values,
// ALU flag bit positions and FSM state encoding.
package alu_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;

  // ALU flag bit indices
  localparam int unsigned FLG_ZERO = 2;
  localparam int unsigned FLG_NEG  = 1;
  localparam int unsigned FLG_OVF  = 0;

  // FSM state encoding
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] READ   = 2'd1;
  localparam logic [1:0] EXEC   = 2'd2;
  localparam logic [1:0] RETIRE = 2'd3;

  // Signed-overflow-trapping ops: add, sub, addi
  function automatic logic is_trap_op(input logic [31:0] instr);
    return ((instr[31:26] == OP_RTYPE) &&
            ((instr[5:0] == FN_ADD) || (instr[5:0] == FN_SUB))) ||
           (instr[31:26] == OP_ADDI);
  endfunction

  // Destination register: rd for R-type, rt otherwise
  function automatic logic [4:0] dest_reg(input logic [31:0] instr);
    return (instr[31:26] == OP_RTYPE) ? instr[15:11] : instr[20:16];
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// 32 x DATA_W register file, async active-low reset.
// Ports:
//   clk_i, rst_ni               clock / async active-low reset
//   wb_we_i/wb_addr_i/wb_data_i writeback port (wins over cfg on same address)
//   cfg_we_i/cfg_addr_i/cfg_data_i preload port
//   ra_addr_i/ra_data_o         combinational read port A
//   rb_addr_i/rb_data_o         combinational read port B
// R0 always reads zero and is never written.
module regfile_2r1w #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wb_we_i,
  input  logic [4:0]        wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic              cfg_we_i,
  input  logic [4:0]        cfg_addr_i,
  input  logic [DATA_W-1:0] cfg_data_i,
  input  logic [4:0]        ra_addr_i,
  output logic [DATA_W-1:0] ra_data_o,
  input  logic [4:0]        rb_addr_i,
  output logic [DATA_W-1:0] rb_data_o
);

  logic [DATA_W-1:0] mem_q [32];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < 32; i++) mem_q[i] <= '0;
    end else begin
      // Both ports may write different registers in the same cycle.
      for (int unsigned i = 1; i < 32; i++) begin
        if (wb_we_i && (wb_addr_i == 5'(i)))
          mem_q[i] <= wb_data_i;
        else if (cfg_we_i && (cfg_addr_i == 5'(i)))
          mem_q[i] <= cfg_data_i;
      end
    end
  end

  assign ra_data_o = (ra_addr_i == 5'd0) ? '0 : mem_q[ra_addr_i];
  assign rb_data_o = (rb_addr_i == 5'd0) ? '0 : mem_q[rb_addr_i];

endmodule

// File: rtl/alu_issue_unit.sv
// ALU issue unit: accepts one MIPS instruction per handshake, reads rs/rt,
// drives a combinational ALU, samples result/flags after ALU_LAT cycles and
// retires (writeback, overflow trap, branch decision or memory request).
// Ports:
//   clk, rst_n                      clock / async active-low reset
//   in_valid/in_ready/in_instr      instruction handshake
//   alu_instr/alu_reg_a/alu_reg_b   registered ALU inputs
//   alu_result/alu_flags            ALU outputs ([2]=zero [1]=neg [0]=ovf)
//   cfg_we/cfg_addr/cfg_wdata       register preload
//   wb_valid/wb_addr/wb_data        writeback pulse
//   ovf_trap, branch_taken          retire pulses
//   mem_req/mem_we/mem_addr/mem_wdata memory request pulse
//   retired_cnt                     retired-instruction counter (wrapping)
module alu_issue_unit
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ALU_LAT = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  output logic [31:0]       alu_instr,
  output logic [DATA_W-1:0] alu_reg_a,
  output logic [DATA_W-1:0] alu_reg_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [2:0]        alu_flags,
  input  logic              cfg_we,
  input  logic [4:0]        cfg_addr,
  input  logic [DATA_W-1:0] cfg_wdata,
  output logic              wb_valid,
  output logic [4:0]        wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              ovf_trap,
  output logic              branch_taken,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [CNT_W-1:0]  retired_cnt
);

  localparam int unsigned LAT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  logic [1:0]        state_q, state_d;
  logic [31:0]       instr_q, instr_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [31:0]       alu_instr_q, alu_instr_d;
  logic [DATA_W-1:0] reg_a_q, reg_a_d, reg_b_q, reg_b_d;
  logic              wb_valid_q, wb_valid_d;
  logic [4:0]        wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              ovf_q, ovf_d, br_q, br_d;
  logic              mreq_q, mreq_d, mwe_q, mwe_d;
  logic [DATA_W-1:0] maddr_q, maddr_d, mwdata_q, mwdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rf_a, rf_b;
  logic [5:0]        opcode;

  // Zero/negative flags are not needed for any retire decision.
  logic unused_flags;
  assign unused_flags = ^alu_flags[FLG_ZERO:FLG_NEG];

  regfile_2r1w #(.DATA_W(DATA_W)) u_rf (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .wb_we_i    (wb_valid_q),
    .wb_addr_i  (wb_addr_q),
    .wb_data_i  (wb_data_q),
    .cfg_we_i   (cfg_we),
    .cfg_addr_i (cfg_addr),
    .cfg_data_i (cfg_wdata),
    .ra_addr_i  (instr_q[25:21]),
    .ra_data_o  (rf_a),
    .rb_addr_i  (instr_q[20:16]),
    .rb_data_o  (rf_b)
  );

  assign opcode = alu_instr_q[31:26];

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    lat_d       = lat_q;
    alu_instr_d = alu_instr_q;
    reg_a_d     = reg_a_q;
    reg_b_d     = reg_b_q;
    wb_valid_d  = 1'b0;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
    ovf_d       = 1'b0;
    br_d        = 1'b0;
    mreq_d      = 1'b0;
    mwe_d       = mwe_q;
    maddr_d     = maddr_q;
    mwdata_d    = mwdata_q;
    cnt_d       = cnt_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          instr_d = in_instr;
          state_d = READ;
        end
      end
      READ: begin
        alu_instr_d = instr_q;
        reg_a_d     = rf_a;
        reg_b_d     = rf_b;
        lat_d       = '0;
        state_d     = EXEC;
      end
      EXEC: begin
        // Retire outputs are registered on the last EXEC edge so they appear
        // as one-cycle pulses during RETIRE.
        if (lat_q == LAT_W'(ALU_LAT - 1)) begin
          state_d = RETIRE;
          if ((opcode == OP_BEQ) || (opcode == OP_BNE)) begin
            br_d = alu_result[0];
          end else if ((opcode == OP_LW) || (opcode == OP_SW)) begin
            mreq_d   = 1'b1;
            mwe_d    = (opcode == OP_SW);
            maddr_d  = alu_result;
            mwdata_d = reg_b_q;
          end else if (is_trap_op(alu_instr_q) && alu_flags[FLG_OVF]) begin
            ovf_d = 1'b1;
          end else begin
            wb_valid_d = 1'b1;
            wb_addr_d  = dest_reg(alu_instr_q);
            wb_data_d  = alu_result;
          end
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      RETIRE: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      instr_q     <= '0;
      lat_q       <= '0;
      alu_instr_q <= '0;
      reg_a_q     <= '0;
      reg_b_q     <= '0;
      wb_valid_q  <= 1'b0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      ovf_q       <= 1'b0;
      br_q        <= 1'b0;
      mreq_q      <= 1'b0;
      mwe_q       <= 1'b0;
      maddr_q     <= '0;
      mwdata_q    <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      lat_q       <= lat_d;
      alu_instr_q <= alu_instr_d;
      reg_a_q     <= reg_a_d;
      reg_b_q     <= reg_b_d;
      wb_valid_q  <= wb_valid_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
      ovf_q       <= ovf_d;
      br_q        <= br_d;
      mreq_q      <= mreq_d;
      mwe_q       <= mwe_d;
      maddr_q     <= maddr_d;
      mwdata_q    <= mwdata_d;
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign alu_instr    = alu_instr_q;
  assign alu_reg_a    = reg_a_q;
  assign alu_reg_b    = reg_b_q;
  assign wb_valid     = wb_valid_q;
  assign wb_addr      = wb_addr_q;
  assign wb_data      = wb_data_q;
  assign ovf_trap     = ovf_q;
  assign branch_taken = br_q;
  assign mem_req      = mreq_q;
  assign mem_we       = mwe_q;
  assign mem_addr     = maddr_q;
  assign mem_wdata    = mwdata_q;
  assign retired_cnt  = cnt_q;

endmodule
